// File: rtl/scalar_regfile_mp_pkg.sv
// ---------------------------------------------------------------------------
// scalar_regfile_mp_pkg
// Shared sizing and types for the scalar register banks (integer and FP).
//   SCALAR_REG_WIDTH : data bits per scalar register
//   SCALAR_REG_DEPTH : registers per bank (power of two)
//   SCALAR_REG_AW    : address width derived from the depth
//   sreg_addr_t      : register index type
//   sreg_data_t      : register data type
// ---------------------------------------------------------------------------
package scalar_regfile_mp_pkg;

   localparam int SCALAR_REG_WIDTH = 64;
   localparam int SCALAR_REG_DEPTH = 32;
   localparam int SCALAR_REG_AW    = $clog2(SCALAR_REG_DEPTH);

   typedef logic [SCALAR_REG_AW-1:0]    sreg_addr_t;
   typedef logic [SCALAR_REG_WIDTH-1:0] sreg_data_t;

endpackage

// File: rtl/scalar_regfile_mp_if.sv
// ---------------------------------------------------------------------------
// scalar_regfile_mp_if
// Bundle of the register-bank access signals between decode/issue plus the
// writeback paths (master side) and the register bank (slave side).
//   rd_addr/rd_data/rd_busy : NUM_RD combinational read ports
//   wr_en/wr_addr/wr_data   : NUM_WR write ports, committed at posedge
//   rsv_en/rsv_addr         : destination reservation (sets busy)
//   busy                    : registered scoreboard vector
//   wr_conflict             : registered pulse, same-address multi-write seen
// ---------------------------------------------------------------------------
interface scalar_regfile_mp_if
   import scalar_regfile_mp_pkg::*;
#(
   parameter int WIDTH  = SCALAR_REG_WIDTH,
   parameter int DEPTH  = SCALAR_REG_DEPTH,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_RD-1:0][AW-1:0]    rd_addr;
   logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic [NUM_WR-1:0]            wr_en;
   logic [NUM_WR-1:0][AW-1:0]    wr_addr;
   logic [NUM_WR-1:0][WIDTH-1:0] wr_data;
   logic                         rsv_en;
   logic [AW-1:0]                rsv_addr;
   logic [DEPTH-1:0]             busy;
   logic                         wr_conflict;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, busy, wr_conflict
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, busy, wr_conflict
   );

endinterface

// File: rtl/scalar_regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// scalar_regfile_mp_scoreboard
// Per-register busy bits for one register bank.
//   clk, reset   : clock, asynchronous active-high reset
//   i_rsv_en     : reserve i_rsv_addr (busy set next cycle)
//   i_rsv_addr   : register to reserve
//   i_wr_en      : per-port effective write enables (already filtered)
//   i_wr_addr    : per-port write addresses (writeback clears busy)
//   i_rd_addr    : per-read-port addresses for the busy lookup
//   o_busy       : registered busy vector
//   o_rd_busy    : busy bit of each read address (pre-update value)
// ---------------------------------------------------------------------------
module scalar_regfile_mp_scoreboard
   import scalar_regfile_mp_pkg::*;
#(
   parameter int DEPTH     = SCALAR_REG_DEPTH,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2,
   parameter bit ZERO_REG0 = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_rsv_en,
   input  logic [$clog2(DEPTH)-1:0]      i_rsv_addr,
   input  logic [NUM_WR-1:0]             i_wr_en,
   input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [DEPTH-1:0]              o_busy,
   output logic [NUM_RD-1:0]             o_rd_busy
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;
   logic             w_rsv_ok;

   // A reservation of the hard-wired zero register is meaningless; drop it
   // so busy[0] can never be set in the integer bank.
   assign w_rsv_ok = i_rsv_en && !(ZERO_REG0 && (i_rsv_addr == '0));

   // Writeback clears first, reservation applied last so it wins when the
   // same register is both written back and re-reserved in one cycle.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int w = 0; w < NUM_WR; w++) begin
         if (i_wr_en[w]) begin
            w_busy_nxt[i_wr_addr[w]] = 1'b0;
         end
      end
      if (w_rsv_ok) begin
         w_busy_nxt[i_rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   always_comb begin
      o_rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         o_rd_busy[p] = r_busy[i_rd_addr[p]];
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/scalar_regfile_mp.sv
// ---------------------------------------------------------------------------
// scalar_regfile_mp
// Multi-port scalar register bank with optional write-through bypass,
// optional hard-wired zero register 0 and a per-register busy scoreboard.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; clears storage, busy and conflict
//   bus    : scalar_regfile_mp_if slave modport (read ports, write ports,
//            reservation, busy vector, wr_conflict pulse)
// ---------------------------------------------------------------------------
module scalar_regfile_mp
   import scalar_regfile_mp_pkg::*;
#(
   parameter int WIDTH     = SCALAR_REG_WIDTH,
   parameter int DEPTH     = SCALAR_REG_DEPTH,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2,
   parameter bit BYPASS    = 1'b1,
   parameter bit ZERO_REG0 = 1'b1
) (
   input logic                clk,
   input logic                reset,
   scalar_regfile_mp_if.slave bus
);

   logic [WIDTH-1:0]             r_mem [DEPTH];
   logic                         r_wr_conflict;
   logic [NUM_WR-1:0]            w_wr_ok;
   logic [NUM_RD-1:0][WIDTH-1:0] w_rd_data;
   logic                         w_conflict;

   // Writes to the zero register are dropped entirely, so they neither
   // update storage nor take part in conflict detection.
   always_comb begin
      w_wr_ok = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         w_wr_ok[w] = bus.wr_en[w] && !(ZERO_REG0 && (bus.wr_addr[w] == '0));
      end
   end

   // Ports are visited in ascending order, so the last (highest-index)
   // matching port's non-blocking write is the one that sticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (w_wr_ok[w]) begin
               r_mem[bus.wr_addr[w]] <= bus.wr_data[w];
            end
         end
      end
   end

   always_comb begin
      w_conflict = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (w_wr_ok[i] && w_wr_ok[j] && (bus.wr_addr[i] == bus.wr_addr[j])) begin
               w_conflict = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_conflict <= 1'b0;
      end else begin
         r_wr_conflict <= w_conflict;
      end
   end

   // Read mux: stored value, overridden by the highest matching same-cycle
   // write when bypassing. Reset and the zero register force 0 last so a
   // live write port cannot leak through either.
   always_comb begin
      w_rd_data = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         w_rd_data[p] = r_mem[bus.rd_addr[p]];
         if (BYPASS) begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p])) begin
                  w_rd_data[p] = bus.wr_data[w];
               end
            end
         end
         if (reset || (ZERO_REG0 && (bus.rd_addr[p] == '0))) begin
            w_rd_data[p] = '0;
         end
      end
   end

   assign bus.rd_data     = w_rd_data;
   assign bus.wr_conflict = r_wr_conflict;

   scalar_regfile_mp_scoreboard #(
      .DEPTH     (DEPTH),
      .NUM_RD    (NUM_RD),
      .NUM_WR    (NUM_WR),
      .ZERO_REG0 (ZERO_REG0)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .i_rsv_en   (bus.rsv_en),
      .i_rsv_addr (bus.rsv_addr),
      .i_wr_en    (w_wr_ok),
      .i_wr_addr  (bus.wr_addr),
      .i_rd_addr  (bus.rd_addr),
      .o_busy     (bus.busy),
      .o_rd_busy  (bus.rd_busy)
   );

endmodule

// File: tb/tb_scalar_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_scalar_regfile_mp
// Two banks driven with identical stimulus: instance 0 is the integer-bank
// configuration (BYPASS=1, ZERO_REG0=1), instance 1 is BYPASS=0, ZERO_REG0=0.
// A behavioural model of both banks is checked against the outputs on every
// falling edge; directed sections pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_scalar_regfile_mp;

   logic clk;
   logic t_reset;

   logic [1:0][4:0]  t_rd_addr;
   logic [1:0]       t_wr_en;
   logic [1:0][4:0]  t_wr_addr;
   logic [1:0][63:0] t_wr_data;
   logic             t_rsv_en;
   logic [4:0]       t_rsv_addr;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   scalar_regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) if_a ();
   scalar_regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) if_b ();

   assign if_a.rd_addr  = t_rd_addr;
   assign if_a.wr_en    = t_wr_en;
   assign if_a.wr_addr  = t_wr_addr;
   assign if_a.wr_data  = t_wr_data;
   assign if_a.rsv_en   = t_rsv_en;
   assign if_a.rsv_addr = t_rsv_addr;
   assign if_b.rd_addr  = t_rd_addr;
   assign if_b.wr_en    = t_wr_en;
   assign if_b.wr_addr  = t_wr_addr;
   assign if_b.wr_data  = t_wr_data;
   assign if_b.rsv_en   = t_rsv_en;
   assign if_b.rsv_addr = t_rsv_addr;

   scalar_regfile_mp #(
      .WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1), .ZERO_REG0(1'b1)
   ) dut_a (
      .clk   (clk),
      .reset (t_reset),
      .bus   (if_a)
   );

   scalar_regfile_mp #(
      .WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0), .ZERO_REG0(1'b0)
   ) dut_b (
      .clk   (clk),
      .reset (t_reset),
      .bus   (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [63:0] m_reg  [2][32];
   logic [31:0] m_busy [2];
   logic        m_conf [2];

   function automatic bit cfg_zr(int k);
      return (k == 0);
   endfunction

   function automatic bit cfg_byp(int k);
      return (k == 0);
   endfunction

   always @(posedge clk or posedge t_reset) begin : model
      if (t_reset) begin
         for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) m_reg[k][r] <= '0;
            m_busy[k] <= '0;
            m_conf[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit c;
            c = 1'b0;
            if (t_wr_en[0] && t_wr_en[1] && (t_wr_addr[0] == t_wr_addr[1]) &&
                !(cfg_zr(k) && (t_wr_addr[0] == 5'd0)))
               c = 1'b1;
            for (int w = 0; w < 2; w++) begin
               if (t_wr_en[w] && !(cfg_zr(k) && (t_wr_addr[w] == 5'd0)))
                  m_reg[k][t_wr_addr[w]] <= t_wr_data[w];
               if (t_wr_en[w] && !(t_rsv_en && (t_rsv_addr == t_wr_addr[w])))
                  m_busy[k][t_wr_addr[w]] <= 1'b0;
            end
            if (t_rsv_en && !(cfg_zr(k) && (t_rsv_addr == 5'd0)))
               m_busy[k][t_rsv_addr] <= 1'b1;
            m_conf[k] <= c;
         end
      end
   end

   function automatic logic [63:0] exp_rd(int k, int p);
      logic [63:0] v;
      logic [4:0]  a;
      a = t_rd_addr[p];
      if (t_reset) return 64'd0;
      if (cfg_zr(k) && (a == 5'd0)) return 64'd0;
      v = m_reg[k][a];
      if (cfg_byp(k)) begin
         for (int w = 0; w < 2; w++)
            if (t_wr_en[w] && (t_wr_addr[w] == a)) v = t_wr_data[w];
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int k, input logic [1:0][63:0] rd, input logic [1:0] rb,
                           input logic [31:0] bz, input logic cf);
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("dut%0d rd_data%0d", k, p), rd[p], exp_rd(k, p));
         chk($sformatf("dut%0d rd_busy%0d", k, p), {63'd0, rb[p]},
             {63'd0, m_busy[k][t_rd_addr[p]]});
      end
      chk($sformatf("dut%0d busy", k), {32'd0, bz}, {32'd0, m_busy[k]});
      chk($sformatf("dut%0d wr_conflict", k), {63'd0, cf}, {63'd0, m_conf[k]});
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (check_en) begin
         cmp_inst(0, if_a.rd_data, if_a.rd_busy, if_a.busy, if_a.wr_conflict);
         cmp_inst(1, if_b.rd_data, if_b.rd_busy, if_b.busy, if_b.wr_conflict);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      t_wr_en    = '0;
      t_wr_addr  = '0;
      t_wr_data  = '0;
      t_rsv_en   = 1'b0;
      t_rsv_addr = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      t_reset   = 1'b1;
      t_rd_addr = '0;
      idle();
      repeat (3) next_cycle();

      // Reads under reset are zero even with a live bypassing write.
      t_wr_en = 2'b01; t_wr_addr[0] = 5'd4; t_wr_data[0] = 64'hABCD; t_rd_addr[0] = 5'd4;
      @(negedge clk);
      chk("reset read bypass a", if_a.rd_data[0], 64'd0);
      chk("reset busy a", {32'd0, if_a.busy}, 64'd0);
      check_en = 1'b1;
      next_cycle();
      idle();
      t_reset = 1'b0;

      // All addresses read back zero after reset.
      for (int a = 0; a < 32; a++) begin
         t_rd_addr[0] = 5'(a);
         t_rd_addr[1] = 5'(31 - a);
         @(negedge clk);
         chk("post-reset rd0 a", if_a.rd_data[0], 64'd0);
         chk("post-reset rd1 b", if_b.rd_data[1], 64'd0);
         next_cycle();
      end
      chk("post-reset busy b", {32'd0, if_b.busy}, 64'd0);
      chk("post-reset conflict a", {63'd0, if_a.wr_conflict}, 64'd0);

      // Write-through bypass versus stored-only read.
      t_wr_en = 2'b01; t_wr_addr[0] = 5'd5; t_wr_data[0] = 64'hDEAD_BEEF; t_rd_addr[0] = 5'd5;
      @(negedge clk);
      chk("bypass rd5 a", if_a.rd_data[0], 64'hDEAD_BEEF);
      chk("no-bypass rd5 b", if_b.rd_data[0], 64'd0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("stored rd5 a", if_a.rd_data[0], 64'hDEAD_BEEF);
      chk("stored rd5 b", if_b.rd_data[0], 64'hDEAD_BEEF);
      next_cycle();

      // Same-address double write: port 1 wins, conflict pulses one cycle later.
      t_wr_en = 2'b11; t_wr_addr[0] = 5'd7; t_wr_addr[1] = 5'd7;
      t_wr_data[0] = 64'h11; t_wr_data[1] = 64'h22; t_rd_addr[0] = 5'd7;
      @(negedge clk);
      chk("dual-wr bypass a", if_a.rd_data[0], 64'h22);
      chk("conflict early a", {63'd0, if_a.wr_conflict}, 64'd0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("dual-wr stored b", if_b.rd_data[0], 64'h22);
      chk("conflict pulse a", {63'd0, if_a.wr_conflict}, 64'd1);
      chk("conflict pulse b", {63'd0, if_b.wr_conflict}, 64'd1);
      next_cycle();
      @(negedge clk);
      chk("conflict clear a", {63'd0, if_a.wr_conflict}, 64'd0);
      next_cycle();

      // Scoreboard: reserve, writeback, reserve+writeback same cycle.
      t_rsv_en = 1'b1; t_rsv_addr = 5'd9; t_rd_addr[1] = 5'd9;
      @(negedge clk);
      chk("rsv not yet a", {63'd0, if_a.busy[9]}, 64'd0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("rsv busy a", {63'd0, if_a.busy[9]}, 64'd1);
      chk("rsv rd_busy a", {63'd0, if_a.rd_busy[1]}, 64'd1);
      next_cycle();
      t_wr_en = 2'b10; t_wr_addr[1] = 5'd9; t_wr_data[1] = 64'h99;
      @(negedge clk);
      chk("wb busy held b", {63'd0, if_b.rd_busy[1]}, 64'd1);
      next_cycle();
      idle();
      @(negedge clk);
      chk("wb clears a", {63'd0, if_a.busy[9]}, 64'd0);
      next_cycle();
      t_rsv_en = 1'b1; t_rsv_addr = 5'd9;
      t_wr_en = 2'b01; t_wr_addr[0] = 5'd9; t_wr_data[0] = 64'h1234;
      next_cycle();
      idle();
      @(negedge clk);
      chk("rsv wins a", {63'd0, if_a.busy[9]}, 64'd1);
      chk("rsv wins data b", if_b.rd_data[1], 64'h1234);
      next_cycle();

      // Register 0 behaviour in both configurations.
      t_wr_en = 2'b01; t_wr_addr[0] = 5'd0; t_wr_data[0] = 64'hFF;
      t_rsv_en = 1'b1; t_rsv_addr = 5'd0; t_rd_addr[0] = 5'd0;
      @(negedge clk);
      chk("zero reg bypass a", if_a.rd_data[0], 64'd0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("zero reg rd a", if_a.rd_data[0], 64'd0);
      chk("zero reg busy a", {63'd0, if_a.busy[0]}, 64'd0);
      chk("reg0 rd b", if_b.rd_data[0], 64'hFF);
      chk("reg0 busy b", {63'd0, if_b.busy[0]}, 64'd1);
      next_cycle();

      // Asynchronous reset between reservation and writeback of reg 3.
      t_wr_en = 2'b01; t_wr_addr[0] = 5'd3; t_wr_data[0] = 64'h55;
      t_rsv_en = 1'b1; t_rsv_addr = 5'd3; t_rd_addr[0] = 5'd3;
      next_cycle();
      idle();
      @(negedge clk);
      chk("pre-reset reg3 b", if_b.rd_data[0], 64'h55);
      chk("pre-reset busy3 a", {63'd0, if_a.busy[3]}, 64'd1);
      next_cycle();
      t_wr_en = 2'b01; t_wr_addr[0] = 5'd3; t_wr_data[0] = 64'h77;
      #2;
      t_reset = 1'b1;
      #1;
      chk("async busy3 a", {63'd0, if_a.busy[3]}, 64'd0);
      chk("async busy b", {32'd0, if_b.busy}, 64'd0);
      chk("async rd3 a", if_a.rd_data[0], 64'd0);
      chk("async rd3 b", if_b.rd_data[0], 64'd0);
      next_cycle();
      idle();
      t_reset = 1'b0;
      @(negedge clk);
      chk("after reset reg3 b", if_b.rd_data[0], 64'd0);
      chk("after reset busy3 b", {63'd0, if_b.busy[3]}, 64'd0);
      next_cycle();

      // Randomised traffic on a narrow address range to provoke collisions.
      for (int i = 0; i < 600; i++) begin
         t_wr_en      = 2'($urandom);
         t_wr_addr[0] = 5'($urandom_range(0, 7));
         t_wr_addr[1] = 5'($urandom_range(0, 7));
         t_wr_data[0] = {$urandom, $urandom};
         t_wr_data[1] = {$urandom, $urandom};
         t_rsv_en     = ($urandom_range(0, 2) == 0);
         t_rsv_addr   = 5'($urandom_range(0, 7));
         t_rd_addr[0] = 5'($urandom_range(0, 7));
         t_rd_addr[1] = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0) t_reset = 1'b1;
         next_cycle();
         t_reset = 1'b0;
      end

      idle();
      next_cycle();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
